// File: rtl/core_wb_pkg.sv
// Shared types and defaults for the core-to-Wishbone bridge.
package core_wb_pkg;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  localparam logic [31:0] DEF_ERR_RDATA      = 32'hDEAD_BEEF;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/wb_timeout_counter.sv
// Counts bus cycles; expired is high while the count sits at LIMIT-1.
import core_wb_pkg::*;

module wb_timeout_counter #(
  parameter int unsigned LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int unsigned   CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  // Saturate at LAST so a held-off clear cannot wrap the count.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear)            r_cnt <= '0;
    else if (i_enable && !o_expired) r_cnt <= r_cnt + CW'(1);
  end

  // LIMIT of zero means the timeout never fires.
  assign o_expired = (LIMIT != 0) && (r_cnt == LAST);
endmodule

// File: rtl/core_wb_bridge.sv
// Single-outstanding core request to Wishbone master (classic or pipelined),
// with an optional ack timeout that completes the access with an error.
import core_wb_pkg::*;

module core_wb_bridge #(
  parameter bit          PIPELINED      = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_RDATA      = DEF_ERR_RDATA
) (
  input  logic        clk_core,
  input  logic        rst_core,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic [3:0]  core_be_i,
  output logic [31:0] core_rdata_o,
  output logic        core_ready_o,
  output logic        core_err_o,
  output logic        core_cyc,
  output logic        core_stb,
  output logic        core_we,
  output logic [3:0]  core_sel,
  output logic [31:0] core_addr,
  output logic [31:0] core_data_out,
  input  logic [31:0] core_data_in,
  input  logic        core_ack
);
  state_e      r_state, w_next;
  logic        r_first, r_we, r_err;
  logic [3:0]  r_sel;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        w_bus, w_accept, w_ack, w_tmo, w_expired;

  assign w_bus    = (r_state == BUS);
  assign w_accept = (r_state == IDLE) && core_req_i;
  assign w_ack    = w_bus && core_ack;
  assign w_tmo    = w_bus && !core_ack && w_expired;

  wb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .i_clk     (clk_core),
    .i_rst     (rst_core),
    .i_clear   (!w_bus),
    .i_enable  (w_bus),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk_core) begin
    if (rst_core) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (core_req_i) w_next = BUS;
      BUS:     if (core_ack || w_expired) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      r_first <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_first <= w_accept;
      if (w_accept) begin
        r_we    <= core_we_i;
        r_addr  <= {core_addr_i[31:2], 2'b00};
        r_wdata <= core_wdata_i;
        r_sel   <= core_we_i ? core_be_i : 4'hF;
      end
      // Ack has priority over a timeout landing in the same cycle.
      if (w_ack) begin
        r_rdata <= r_we ? '0 : core_data_in;
        r_err   <= 1'b0;
      end else if (w_tmo) begin
        r_rdata <= r_we ? '0 : ERR_RDATA;
        r_err   <= 1'b1;
      end
    end
  end

  assign core_cyc      = w_bus;
  assign core_stb      = w_bus && (PIPELINED ? r_first : 1'b1);
  assign core_we       = r_we;
  assign core_sel      = r_sel;
  assign core_addr     = r_addr;
  assign core_data_out = r_wdata;
  assign core_ready_o  = (r_state == RESP);
  assign core_rdata_o  = r_rdata;
  assign core_err_o    = r_err;
endmodule

// File: tb/tb_core_wb_bridge.sv
// Bench for core_wb_bridge: classic and pipelined instances share stimulus.
module tb_core_wb_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0, ack = 1'b0;
  logic [31:0] addr = '0, wdata = '0, sdin = '0;
  logic [3:0]  be = '0;

  logic [31:0] d0_rdata, d0_addr, d0_dout, d1_rdata, d1_addr, d1_dout;
  logic        d0_ready, d0_err, d0_cyc, d0_stb, d0_we;
  logic        d1_ready, d1_err, d1_cyc, d1_stb, d1_we;
  logic [3:0]  d0_sel, d1_sel;

  always #5 clk = ~clk;

  core_wb_bridge #(.PIPELINED(1'b0), .TIMEOUT_CYCLES(8)) u_dut0 (
    .clk_core(clk), .rst_core(rst), .core_req_i(req), .core_we_i(we),
    .core_addr_i(addr), .core_wdata_i(wdata), .core_be_i(be),
    .core_rdata_o(d0_rdata), .core_ready_o(d0_ready), .core_err_o(d0_err),
    .core_cyc(d0_cyc), .core_stb(d0_stb), .core_we(d0_we), .core_sel(d0_sel),
    .core_addr(d0_addr), .core_data_out(d0_dout), .core_data_in(sdin), .core_ack(ack));

  core_wb_bridge #(.PIPELINED(1'b1), .TIMEOUT_CYCLES(8)) u_dut1 (
    .clk_core(clk), .rst_core(rst), .core_req_i(req), .core_we_i(we),
    .core_addr_i(addr), .core_wdata_i(wdata), .core_be_i(be),
    .core_rdata_o(d1_rdata), .core_ready_o(d1_ready), .core_err_o(d1_err),
    .core_cyc(d1_cyc), .core_stb(d1_stb), .core_we(d1_we), .core_sel(d1_sel),
    .core_addr(d1_addr), .core_data_out(d1_dout), .core_data_in(sdin), .core_ack(ack));

  typedef struct {
    string       nm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          wait_n;   // bus cycle index that gets ack, -1 = never
    logic [31:0] sdata;
    logic [31:0] e_addr;
    logic [3:0]  e_sel;
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_lat;    // request cycle to ready pulse
    int          e_cyc;    // cycles with cyc high
    int          e_stb0;   // cycles with stb high, classic instance
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vt[7];
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cyc"},   32'(d0_cyc),   32'd0);
    chk({tag, "_stb"},   32'(d0_stb),   32'd0);
    chk({tag, "_we"},    32'(d0_we),    32'd0);
    chk({tag, "_sel"},   32'(d0_sel),   32'd0);
    chk({tag, "_addr"},  d0_addr,       32'd0);
    chk({tag, "_dout"},  d0_dout,       32'd0);
    chk({tag, "_rdata"}, d0_rdata,      32'd0);
    chk({tag, "_ready"}, 32'(d0_ready), 32'd0);
    chk({tag, "_err"},   32'(d0_err),   32'd0);
  endtask

  task automatic run(input vec_t v);
    int   k, b, stb0, stb1, cyc0, cyc1;
    bit   done, seen, unstable;
    exp_t e;
    @(posedge clk); #1;
    req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata; be = v.be; ack = 1'b0;
    e.rdata = v.e_rdata; e.err = v.e_err; e.lat = v.e_lat;
    sb.push_back(e);
    k = 0; b = 0; stb0 = 0; stb1 = 0; cyc0 = 0; cyc1 = 0;
    done = 1'b0; seen = 1'b0; unstable = 1'b0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (d1_stb) stb1++;
      if (d1_cyc) cyc1++;
      if (d0_cyc) begin
        if (!seen) begin
          seen = 1'b1;
          chk({v.nm, "_addr"}, d0_addr, v.e_addr);
          chk({v.nm, "_sel"},  32'(d0_sel), 32'(v.e_sel));
          chk({v.nm, "_we"},   32'(d0_we), 32'(v.we));
          chk({v.nm, "_dout"}, d0_dout, v.wdata);
        end else if (d0_addr !== v.e_addr || d0_sel !== v.e_sel ||
                     d0_we !== v.we || d0_dout !== v.wdata) begin
          unstable = 1'b1;
        end
        cyc0++;
        if (d0_stb) stb0++;
        ack  = (b == v.wait_n);
        sdin = ack ? v.sdata : $urandom;
        b++;
        // Core side wanders while the access is in flight.
        addr = $urandom; wdata = $urandom; be = 4'($urandom); we = 1'($urandom);
      end else begin
        ack = 1'b0;
      end
      if (d0_ready) begin
        done = 1'b1;
        req  = 1'b0;
        if (sb.size() == 0) begin
          chk({v.nm, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          chk({v.nm, "_rdata"}, d0_rdata, e.rdata);
          chk({v.nm, "_err"},   32'(d0_err), 32'(e.err));
          chk({v.nm, "_lat"},   32'(k), 32'(e.lat));
          chk({v.nm, "_p_ready"}, 32'(d1_ready), 32'd1);
          chk({v.nm, "_p_rdata"}, d1_rdata, e.rdata);
        end
      end
    end
    if (!done) begin
      chk({v.nm, "_ready_timeout"}, 32'd0, 32'd1);
      req = 1'b0; ack = 1'b0;
      sb.delete();
    end
    chk({v.nm, "_stb_cycles"},   32'(stb0), 32'(v.e_stb0));
    chk({v.nm, "_cyc_cycles"},   32'(cyc0), 32'(v.e_cyc));
    chk({v.nm, "_p_stb_cycles"}, 32'(stb1), 32'd1);
    chk({v.nm, "_p_cyc_cycles"}, 32'(cyc1), 32'(v.e_cyc));
    chk({v.nm, "_held"},         32'(unstable), 32'd0);
    @(posedge clk); #1;
    chk({v.nm, "_one_pulse"}, 32'(d0_ready), 32'd0);
    chk({v.nm, "_idle_cyc"},  32'(d0_cyc),   32'd0);
  endtask

  initial begin
    //        nm      we    addr           wdata          be     wait sdata          e_addr         e_sel  e_rdata        err   lat cyc stb
    vt[0] = '{"rd0w", 1'b0, 32'h0000_1006, 32'h0BAD_F00D, 4'h0,   0, 32'h1234_5678, 32'h0000_1004, 4'hF, 32'h1234_5678, 1'b0, 2, 1, 1};
    vt[1] = '{"wr3w", 1'b1, 32'h0000_2000, 32'hAABB_CCDD, 4'h3,   3, 32'h9999_9999, 32'h0000_2000, 4'h3, 32'h0000_0000, 1'b0, 5, 4, 4};
    vt[2] = '{"rd2w", 1'b0, 32'h0000_3003, 32'h0000_0000, 4'hF,   2, 32'hCAFE_F00D, 32'h0000_3000, 4'hF, 32'hCAFE_F00D, 1'b0, 4, 3, 3};
    vt[3] = '{"wr1w", 1'b1, 32'h0000_5001, 32'h0102_0304, 4'hC,   1, 32'h7777_7777, 32'h0000_5000, 4'hC, 32'h0000_0000, 1'b0, 3, 2, 2};
    vt[4] = '{"rdlst",1'b0, 32'h7FFF_FFFF, 32'h1111_2222, 4'h5,   7, 32'h1357_9BDF, 32'h7FFF_FFFC, 4'hF, 32'h1357_9BDF, 1'b0, 9, 8, 8};
    vt[5] = '{"rdtmo",1'b0, 32'h0000_4008, 32'h3333_4444, 4'h0,  -1, 32'h0000_0000, 32'h0000_4008, 4'hF, 32'hDEAD_BEEF, 1'b1, 9, 8, 8};
    vt[6] = '{"wrbe0",1'b1, 32'hFFFF_FFFE, 32'h5A5A_5A5A, 4'h0,   0, 32'h2468_ACE0, 32'hFFFF_FFFC, 4'h0, 32'h0000_0000, 1'b0, 2, 1, 1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run(vt[i]);

    // Ack arriving after a timed-out access must not start or finish anything.
    run(vt[5]);
    ack = 1'b1; sdin = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("spur_ready", 32'(d0_ready), 32'd0);
      chk("spur_cyc",   32'(d0_cyc),   32'd0);
    end
    ack = 1'b0;

    // Reset during the second bus cycle aborts silently.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 32'h0000_6004; wdata = 32'hFEED_FACE; be = 4'hF;
    @(posedge clk); #1;
    chk("rbus_cyc1", 32'(d0_cyc), 32'd1);
    @(posedge clk); #1;
    chk("rbus_cyc2", 32'(d0_cyc), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    chk_zero("rbus");
    chk("rbus_p_cyc", 32'(d1_cyc), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rbus_no_ready", 32'(d0_ready), 32'd0);
      chk("rbus_idle",     32'(d0_cyc),   32'd0);
    end
    run(vt[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
